// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with credit-limited requests, an in-order
// response queue, and redirect that flushes the queue and drops in-flight responses.
module fetch_unit #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] r_count, r_inflight, r_drop;
   logic [AW-1:0] r_rd, r_wr;
   logic [31:0]   r_fetch_pc, r_resp_pc;
   logic [31:0]   r_q_pc   [DEPTH];
   logic [31:0]   r_q_inst [DEPTH];

   logic          w_credit, w_req_fire, w_resp_fire, w_push, w_pop;
   logic [CW-1:0] w_inflight_n;
   logic [31:0]   w_rpc;

   // Outstanding requests plus buffered entries never exceed DEPTH, so every response has a slot.
   assign w_credit       = ({1'b0, r_inflight} + {1'b0, r_count}) < (CW+1)'(DEPTH);
   assign imem_req_valid = !rst && w_credit;
   assign imem_req_addr  = r_fetch_pc;
   assign inst_valid     = r_count != '0;
   assign inst           = r_q_inst[r_rd];
   assign inst_pc        = r_q_pc[r_rd];

   assign w_req_fire   = imem_req_valid && imem_req_ready;
   assign w_resp_fire  = imem_resp_valid;
   assign w_push       = w_resp_fire && r_drop == '0;
   assign w_pop        = inst_valid && inst_ready;
   assign w_inflight_n = r_inflight + CW'(w_req_fire) - CW'(w_resp_fire);
   assign w_rpc        = redirect_pc & ~32'h3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop     <= '0;
         r_rd       <= '0;
         r_wr       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_pc[i]   <= '0;
            r_q_inst[i] <= '0;
         end
      end else begin
         r_inflight <= w_inflight_n;
         if (redirect_valid) begin
            r_fetch_pc <= w_rpc;
            r_resp_pc  <= w_rpc;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_drop     <= w_inflight_n;
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_resp_fire && r_drop != '0) r_drop <= r_drop - 1'b1;
            if (w_push) begin
               r_q_pc[r_wr]   <= r_resp_pc;
               r_q_inst[r_wr] <= imem_resp_data;
               r_wr           <= r_wr + 1'b1;
               r_resp_pc      <= r_resp_pc + 32'd4;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end
endmodule
